// File: rtl/hazard_ctrl_pkg.sv
// Shared constants for the pipeline stall controller: StallBus patterns and FSM encodings.
package hazard_ctrl_pkg;

  localparam int StallBus = 6;
  localparam logic Stop = 1'b1;

  localparam logic [StallBus-1:0] STALL_NONE = 6'b000000;
  localparam logic [StallBus-1:0] STALL_LU   = 6'b000111;
  localparam logic [StallBus-1:0] STALL_EX   = 6'b001111;

  localparam logic [1:0] HZ_RUN = 2'd0;
  localparam logic [1:0] HZ_LU  = 2'd1;
  localparam logic [1:0] HZ_EX  = 2'd2;

  // EX-busy outranks load-use: it must also freeze EX and bubble MEM
  function automatic logic [StallBus-1:0] stall_pattern(input logic req_id, input logic req_ex);
    if (req_ex)      return STALL_EX;
    else if (req_id) return STALL_LU;
    else             return STALL_NONE;
  endfunction

endpackage

// File: rtl/inst_hold_buf.sv
// Instruction hold buffer: keeps ID's word stable while the SRAM output moves under a stalled fetch.
module inst_hold_buf (
  input  logic        clk,
  input  logic        resetn,
  input  logic        hold_en,
  input  logic [31:0] rdata_in,
  output logic [31:0] inst_out
);

  logic        hold_valid;
  logic [31:0] hold_inst;

  // Recirculating the presented word freezes it for the whole episode plus one cycle after release
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hold_valid <= 1'b0;
      hold_inst  <= 32'h0;
    end else begin
      hold_valid <= hold_en;
      hold_inst  <= inst_out;
    end
  end

  assign inst_out = hold_valid ? hold_inst : rdata_in;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline stall controller: merges ID/EX stall requests, tracks the episode, owns the ID hold buffer.
// Optional stall counters are built when HAZARD_STALL_CNT_EN is defined.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                stallreq_id,
  input  logic                stallreq_ex,
  input  logic [31:0]         inst_sram_rdata,
  output logic [StallBus-1:0] stall,
  output logic [31:0]         id_inst,
  output logic [1:0]          ctrl_state,
  output logic                stall_release,
  output logic [CNT_W-1:0]    lu_stall_cnt,
  output logic [CNT_W-1:0]    ex_stall_cnt
);

  logic [1:0] state_q;
  logic [1:0] state_d;

  assign stall = stall_pattern(stallreq_id, stallreq_ex);

  always_comb begin
    state_d = HZ_RUN;
    if (stallreq_ex)      state_d = HZ_EX;
    else if (stallreq_id) state_d = HZ_LU;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= HZ_RUN;
    else         state_q <= state_d;
  end

  assign ctrl_state    = state_q;
  assign stall_release = (state_q != HZ_RUN) && !stallreq_ex && !stallreq_id;

  inst_hold_buf u_hold (
    .clk      (clk),
    .resetn   (resetn),
    .hold_en  (stall[1] == Stop),
    .rdata_in (inst_sram_rdata),
    .inst_out (id_inst)
  );

`ifdef HAZARD_STALL_CNT_EN
  logic [CNT_W-1:0] lu_cnt_q;
  logic [CNT_W-1:0] ex_cnt_q;

  // Both counters stick at all-ones rather than wrapping
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lu_cnt_q <= '0;
      ex_cnt_q <= '0;
    end else begin
      if (stall == STALL_LU && lu_cnt_q != {CNT_W{1'b1}}) lu_cnt_q <= lu_cnt_q + 1'b1;
      if (stall[3] == Stop && ex_cnt_q != {CNT_W{1'b1}}) ex_cnt_q <= ex_cnt_q + 1'b1;
    end
  end

  assign lu_stall_cnt = lu_cnt_q;
  assign ex_stall_cnt = ex_cnt_q;
`else
  assign lu_stall_cnt = '0;
  assign ex_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: a reference model pushes expected outputs into a scoreboard queue.
module tb_hazard_ctrl;

  localparam int CNT_W = 6;
  localparam logic [31:0] WORD_R = 32'h2408_0001;
  localparam logic [31:0] WORD_A = 32'h8c02_0000;
  localparam logic [31:0] WORD_B = 32'h0000_0b0b;

  logic             clk;
  logic             resetn;
  logic             stallreq_id;
  logic             stallreq_ex;
  logic [31:0]      inst_sram_rdata;
  logic [5:0]       stall;
  logic [31:0]      id_inst;
  logic [1:0]       ctrl_state;
  logic             stall_release;
  logic [CNT_W-1:0] lu_stall_cnt;
  logic [CNT_W-1:0] ex_stall_cnt;

  typedef struct {
    logic [5:0]       stall;
    logic [1:0]       state;
    logic             rel;
    logic [31:0]      inst;
    logic [CNT_W-1:0] lu;
    logic [CNT_W-1:0] ex;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_errors = 0;

  logic [1:0]       m_state;
  logic             m_hold_valid;
  logic [31:0]      m_hold_inst;
  logic [CNT_W-1:0] m_lu;
  logic [CNT_W-1:0] m_ex;

  hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .stallreq_id     (stallreq_id),
    .stallreq_ex     (stallreq_ex),
    .inst_sram_rdata (inst_sram_rdata),
    .stall           (stall),
    .id_inst         (id_inst),
    .ctrl_state      (ctrl_state),
    .stall_release   (stall_release),
    .lu_stall_cnt    (lu_stall_cnt),
    .ex_stall_cnt    (ex_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  task automatic model_clear();
    m_state      = 2'd0;
    m_hold_valid = 1'b0;
    m_hold_inst  = 32'h0;
    m_lu         = '0;
    m_ex         = '0;
  endtask

  // Builds the expected outputs from the current inputs and model state, then queues them
  task automatic push_expected();
    exp_t e;
    if (stallreq_ex)      e.stall = 6'b001111;
    else if (stallreq_id) e.stall = 6'b000111;
    else                  e.stall = 6'b000000;
    e.state = m_state;
    e.rel   = (m_state != 2'd0) && !stallreq_ex && !stallreq_id;
    e.inst  = m_hold_valid ? m_hold_inst : inst_sram_rdata;
`ifdef HAZARD_STALL_CNT_EN
    e.lu = m_lu;
    e.ex = m_ex;
`else
    e.lu = '0;
    e.ex = '0;
`endif
    exp_q.push_back(e);
  endtask

  task automatic compare_outputs(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      check_output({tag, ".queue"}, 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    check_output({tag, ".stall"}, {26'd0, stall}, {26'd0, e.stall});
    check_output({tag, ".state"}, {30'd0, ctrl_state}, {30'd0, e.state});
    check_output({tag, ".release"}, {31'd0, stall_release}, {31'd0, e.rel});
    check_output({tag, ".id_inst"}, id_inst, e.inst);
    check_output({tag, ".lu_cnt"}, {{(32-CNT_W){1'b0}}, lu_stall_cnt}, {{(32-CNT_W){1'b0}}, e.lu});
    check_output({tag, ".ex_cnt"}, {{(32-CNT_W){1'b0}}, ex_stall_cnt}, {{(32-CNT_W){1'b0}}, e.ex});
  endtask

  // Advances the model to what the DUT should hold after the coming rising edge
  task automatic model_step();
    logic [5:0] s;
    if (!resetn) begin
      model_clear();
      return;
    end
    s = stallreq_ex ? 6'b001111 : (stallreq_id ? 6'b000111 : 6'b000000);
    m_hold_inst  = m_hold_valid ? m_hold_inst : inst_sram_rdata;
    m_hold_valid = s[1];
    if (s == 6'b000111 && m_lu != {CNT_W{1'b1}}) m_lu = m_lu + 1'b1;
    if (s[3] && m_ex != {CNT_W{1'b1}}) m_ex = m_ex + 1'b1;
    m_state = stallreq_ex ? 2'd2 : (stallreq_id ? 2'd1 : 2'd0);
  endtask

  task automatic apply_stimulus(input string tag, input logic rst, input logic req_id,
                                input logic req_ex, input logic [31:0] rdata);
    @(negedge clk);
    resetn          = rst;
    stallreq_id     = req_id;
    stallreq_ex     = req_ex;
    inst_sram_rdata = rdata;
    if (!rst) model_clear();
    #1;
    push_expected();
    compare_outputs(tag);
    model_step();
  endtask

  initial begin
    resetn          = 1'b0;
    stallreq_id     = 1'b0;
    stallreq_ex     = 1'b0;
    inst_sram_rdata = WORD_R;
    model_clear();

    apply_stimulus("reset", 1'b0, 1'b0, 1'b0, WORD_R);
    apply_stimulus("reset", 1'b0, 1'b0, 1'b0, WORD_R);
    apply_stimulus("run", 1'b1, 1'b0, 1'b0, WORD_R);

    apply_stimulus("lu1", 1'b1, 1'b1, 1'b0, WORD_A);
    apply_stimulus("lu1.rel", 1'b1, 1'b0, 1'b0, WORD_B);
    apply_stimulus("lu1.after", 1'b1, 1'b0, 1'b0, WORD_B);

    for (int i = 0; i < 33; i++)
      apply_stimulus("exbusy", 1'b1, 1'b0, 1'b1, 32'h1000_0000 + i);
    apply_stimulus("exbusy.rel", 1'b1, 1'b0, 1'b0, 32'h2000_0000);
    apply_stimulus("exbusy.after", 1'b1, 1'b0, 1'b0, 32'h2000_0001);

    for (int i = 0; i < 3; i++)
      apply_stimulus("overlap.both", 1'b1, 1'b1, 1'b1, 32'h3000_0000 + i);
    apply_stimulus("overlap.id", 1'b1, 1'b1, 1'b0, 32'h3000_0010);
    apply_stimulus("overlap.rel", 1'b1, 1'b0, 1'b0, 32'h3000_0020);
    apply_stimulus("overlap.after", 1'b1, 1'b0, 1'b0, 32'h3000_0030);

    for (int i = 0; i < 4; i++)
      apply_stimulus("midrst.ex", 1'b1, 1'b0, 1'b1, 32'h4000_0000 + i);
    apply_stimulus("midrst.assert", 1'b0, 1'b0, 1'b1, 32'h4000_0100);
    apply_stimulus("midrst.hold", 1'b0, 1'b0, 1'b0, 32'h4000_0200);
    apply_stimulus("midrst.run", 1'b1, 1'b0, 1'b0, 32'h4000_0300);

    for (int i = 0; i < 70; i++)
      apply_stimulus("lu.sat", 1'b1, 1'b1, 1'b0, 32'h5000_0000 + i);
    apply_stimulus("lu.sat.rel", 1'b1, 1'b0, 1'b0, 32'h5000_1000);

    for (int i = 0; i < 80; i++)
      apply_stimulus("random", 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
                     $urandom());
    apply_stimulus("final", 1'b1, 1'b0, 1'b0, 32'h6000_0000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline stall controller for the five-stage CPU core. It merges the decode-stage load-use request and the execute-stage multi-cycle-busy request into the shared `StallBus` vector consumed by every pipeline register. It tracks the current stall episode in a small FSM. It also owns the instruction hold buffer that keeps ID's instruction word stable while the synchronous instruction SRAM output moves on underneath a stalled fetch.

## Interface
Parameters:
- `CNT_W`, default 32: width of the stall performance counters.

Ports:
- `clk` in 1: core clock; all state updates on rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `stallreq_id` in 1: load-use hazard request from ID.
- `stallreq_ex` in 1: multi-cycle unit busy request from EX.
- `inst_sram_rdata` in 32: raw instruction SRAM read data.
- `stall` out `StallBus` (6): per-stage stop; bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; `Stop` = 1.
- `id_inst` out 32: instruction word presented to ID decode.
- `ctrl_state` out 2: FSM state, for debug.
- `stall_release` out 1: one-cycle pulse on the first cycle after a stall episode ends.
- `lu_stall_cnt` out `CNT_W`: load-use stall cycle count.
- `ex_stall_cnt` out `CNT_W`: EX-busy stall cycle count.

## Operation
- `stall` is combinational from the current requests, with priority EX over ID:
  - `stallreq_ex` = 1 → `6'b001111` (PC, IF, ID, EX held; MEM receives a bubble).
  - else `stallreq_id` = 1 → `6'b000111` (PC, IF, ID held; EX receives a bubble).
  - else `6'b000000`.
- FSM states are `RUN` = 0, `LU` = 1, `EX` = 2. State is registered each edge from the current requests:
  - next = `EX` if `stallreq_ex`;
  - else next = `LU` if `stallreq_id`;
  - else next = `RUN`.
  - All transitions, including `LU`↔`EX`, are legal and take effect directly.
- `stall_release` = (state ≠ `RUN`) & !`stallreq_ex` & !`stallreq_id`. It is combinational and high for exactly one cycle per episode end.
- Hold buffer:
  - `hold_valid` ← `stall[1]` every edge.
  - `hold_inst` ← `id_inst` every edge.
  - `id_inst` = `hold_valid` ? `hold_inst` : `inst_sram_rdata`.
  - Effect: the word present on the first stall cycle is frozen for every following stall cycle and for the first cycle after release. This covers the SRAM's one-cycle read latency.
- Counters: `lu_stall_cnt` increments in every cycle where `stall` = `6'b000111`; `ex_stall_cnt` increments in every cycle where `stall[3]` = 1. Both saturate at all-ones and never wrap.

## Timing
- Reset (async assert, sync-to-clk deassert handled by the core reset tree):
  - state = `RUN`, `hold_valid` = 0, `hold_inst` = 0, counters = 0.
  - Hence `stall` = 0 (given no requests), `stall_release` = 0, `id_inst` = `inst_sram_rdata`.
- `stall` latency is zero cycles from request; state and counters lag by one edge.
- Simultaneous `stallreq_id` & `stallreq_ex`: the EX pattern is applied, only `ex_stall_cnt` counts, and next state = `EX`.
- Back-to-back episodes (request drops for 0 cycles while its type changes) produce no `stall_release`.
- Reset asserted mid-stall: state, buffer and counters clear immediately. `id_inst` falls through to SRAM data on the same cycle.
- A load-use stall lasts exactly as long as `stallreq_id` is high; the controller adds no minimum or maximum.

## Configuration
- `HAZARD_STALL_CNT_EN` defined: both counters are built as specified.
- Not defined: counter registers are omitted, and `lu_stall_cnt` / `ex_stall_cnt` are tied to 0 with ports retained. All other behaviour is identical.

## Structure
- Add to `lib/defines.vh`: `STALL_NONE` = `6'b000000`, `STALL_LU` = `6'b000111`, `STALL_EX` = `6'b001111`, and the FSM encodings `HZ_RUN` / `HZ_LU` / `HZ_EX`. Reuse the existing `StallBus`, `Stop` and `NoStop`.
- One sub-module, `inst_hold_buf`: `clk`, `resetn`, `hold_en` (= `stall[1]`), `rdata_in`, `inst_out`. It contains `hold_valid`, `hold_inst` and the output mux.

## Test plan
- **Reset:** `resetn` = 0 with `stallreq_id` = 0 and `stallreq_ex` = 0 → `stall` = 0, `ctrl_state` = 0, counters = 0; `id_inst` tracks `inst_sram_rdata` = `32'h2408_0001`.
- **Single load-use:** `stallreq_id` = 1 for 1 cycle with rdata `A` = `32'h8c02_0000`, then rdata `B` → `stall` = `6'b000111` for 1 cycle; `id_inst` = `A` on the stall cycle and on the next cycle, then `B`; `stall_release` pulses once; `lu_stall_cnt` = 1.
- **EX busy:** `stallreq_ex` = 1 for 33 cycles → `stall` = `6'b001111` throughout; `ctrl_state` = 2 from cycle 2; `ex_stall_cnt` = 33; `id_inst` frozen for 34 cycles.
- **Overlap:** `stallreq_id` and `stallreq_ex` both high for 3 cycles, then `stallreq_id` alone for 1 → `6'b001111`×3 then `6'b000111`×1; states go `EX`→`LU`; no `stall_release` until both are low.
- **Mid-stall reset:** `resetn` pulsed low during cycle 5 of an EX stall → state 0, counters 0, and `id_inst` = live SRAM data within the same cycle.
- **Saturation (`HAZARD_STALL_CNT_EN`, `CNT_W` = 4):** 20 load-use stall cycles → `lu_stall_cnt` = 15, and it holds there.
